// File: rtl/dp_pkg.sv
// Shared definitions for the 4-bit datapath sequencer: opcodes, FSM states,
// instruction field positions and a register-readback helper.
package dp_pkg;

  localparam int INSTR_W = 10;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_BRZ = 2'b10;
  localparam logic [1:0] OP_HLT = 2'b11;

  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 8;
  localparam int RW_MSB  = 7;
  localparam int RW_LSB  = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 2;
  localparam int AOP_BIT = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_t;

  function automatic logic [3:0] reg_pick(input logic [1:0] sel,
                                          input logic [3:0] r0, input logic [3:0] r1,
                                          input logic [3:0] r2, input logic [3:0] r3);
    case (sel)
      2'd0:    reg_pick = r0;
      2'd1:    reg_pick = r1;
      2'd2:    reg_pick = r2;
      default: reg_pick = r3;
    endcase
  endfunction

endpackage

// File: rtl/dp_decode.sv
// Combinational instruction decode: drives datapath controls only while in EXEC
// and tells the sequencer how the PC moves next.
module dp_decode
  import dp_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic               in_exec,
  input  logic [3:0]         r0,
  input  logic [3:0]         r1,
  input  logic [3:0]         r2,
  input  logic [3:0]         r3,
  output logic [1:0]         sel_a,
  output logic [1:0]         sel_b,
  output logic [1:0]         sel_w,
  output logic [3:0]         imm,
  output logic               sel_data,
  output logic               write_en,
  output logic               alu_op,
  output logic [3:0]         target,
  output logic               br_taken,
  output pc_sel_t            pc_sel
);

  logic [1:0] opcode;
  logic       rs_zero;

  assign opcode  = instr[OP_MSB:OP_LSB];
  assign target  = instr[IMM_MSB:IMM_LSB];
  assign rs_zero = (reg_pick(instr[RW_MSB:RW_LSB], r0, r1, r2, r3) == 4'h0);

  always_comb begin
    sel_a    = 2'd0;
    sel_b    = 2'd0;
    sel_w    = 2'd0;
    imm      = 4'h0;
    sel_data = 1'b0;
    write_en = 1'b0;
    alu_op   = 1'b0;
    br_taken = 1'b0;
    pc_sel   = PC_HOLD;
    if (in_exec) begin
      case (opcode)
        OP_LDI: begin
          sel_w    = instr[RW_MSB:RW_LSB];
          imm      = instr[IMM_MSB:IMM_LSB];
          sel_data = 1'b1;
          write_en = 1'b1;
          pc_sel   = PC_INC;
        end
        OP_ALU: begin
          sel_a    = instr[RA_MSB:RA_LSB];
          sel_b    = instr[RB_MSB:RB_LSB];
          sel_w    = instr[RW_MSB:RW_LSB];
          alu_op   = instr[AOP_BIT];
          write_en = 1'b1;
          pc_sel   = PC_INC;
        end
        OP_BRZ: begin
          br_taken = rs_zero;
          pc_sel   = rs_zero ? PC_TARGET : PC_INC;
        end
        default: pc_sel = PC_HOLD;
      endcase
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// Top-level controller for the 4-bit datapath: fetches from a synchronous ROM,
// decodes, sequences PC and counts retired instructions.
module dp_sequencer
  import dp_pkg::*;
#(
  parameter logic [3:0] START_ADDR = 4'd0,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [3:0]       imem_addr,
  input  logic [9:0]       imem_data,
  input  logic [3:0]       R3,
  input  logic [3:0]       R2,
  input  logic [3:0]       R1,
  input  logic [3:0]       R0,
  output logic [1:0]       SEL_A,
  output logic [1:0]       SEL_B,
  output logic [1:0]       SEL_W,
  output logic [3:0]       IMM,
  output logic             sel_data,
  output logic             write_en,
  output logic             alu_op,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] icount
);

  state_t     state;
  logic [3:0] pc;
  logic [3:0] target;
  logic       br_taken;
  pc_sel_t    pc_sel;

  dp_decode u_decode (
    .instr    (imem_data),
    .in_exec  (state == S_EXEC),
    .r0       (R0),
    .r1       (R1),
    .r2       (R2),
    .r3       (R3),
    .sel_a    (SEL_A),
    .sel_b    (SEL_B),
    .sel_w    (SEL_W),
    .imm      (IMM),
    .sel_data (sel_data),
    .write_en (write_en),
    .alu_op   (alu_op),
    .target   (target),
    .br_taken (br_taken),
    .pc_sel   (pc_sel)
  );

  assign imem_addr = pc;
  assign busy      = (state == S_FETCH) || (state == S_EXEC);
  assign done      = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= START_ADDR;
      icount <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc     <= START_ADDR;
            icount <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          // Count saturates so long runs never read back as a small number.
          if (icount != {CNT_W{1'b1}}) icount <= icount + CNT_W'(1);
          if (pc_sel == PC_HOLD) begin
            state <= S_HALT;
          end else begin
            state <= S_FETCH;
            pc    <= br_taken ? target : pc + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
